// File: rtl/wishbone_bus_if.sv
// CPU-to-Wishbone bridge: one outstanding classic cycle, stall handshake with ctrl.
// Optional bus timeout abort enabled by defining WB_BUS_TIMEOUT_EN.
module wishbone_bus_if #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic        cpu_ce_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_data_i,
  input  logic        cpu_we_i,
  input  logic [3:0]  cpu_sel_i,
  output logic [31:0] cpu_data_o,
  output logic        stallreq_o,
  input  logic [31:0] wishbone_data_i,
  input  logic        wishbone_ack_i,
  output logic [31:0] wishbone_addr_o,
  output logic [31:0] wishbone_data_o,
  output logic        wishbone_we_o,
  output logic [3:0]  wishbone_sel_o,
  output logic        wishbone_stb_o,
  output logic        wishbone_cyc_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    BUSY           = 2'd1,
    WAIT_FOR_STALL = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] rd_buf_r;
  logic        timeout_s;

`ifdef WB_BUS_TIMEOUT_EN
  logic [15:0] tmo_cnt_r;
  logic        bus_err_r;

  assign timeout_s = (state_r == BUSY) && !wishbone_ack_i &&
                     (tmo_cnt_r == 16'(TIMEOUT_CYCLES - 32'd1));
  assign bus_err_o = bus_err_r;

  // The count is held at zero outside BUSY, so every new cycle starts fresh
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= 16'd0;
      bus_err_r <= 1'b0;
    end else begin
      bus_err_r <= timeout_s;
      if (state_r != BUSY || wishbone_ack_i || timeout_s) begin
        tmo_cnt_r <= 16'd0;
      end else begin
        tmo_cnt_r <= tmo_cnt_r + 16'd1;
      end
    end
  end
`else
  logic [15:0] unused_tmo_s;

  assign unused_tmo_s = 16'(TIMEOUT_CYCLES);
  assign timeout_s    = 1'b0;
  assign bus_err_o    = 1'b0;
`endif

  // Bus cycle FSM; Wishbone outputs are registered and return to zero when idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= IDLE;
      rd_buf_r        <= 32'd0;
      wishbone_addr_o <= 32'd0;
      wishbone_data_o <= 32'd0;
      wishbone_we_o   <= 1'b0;
      wishbone_sel_o  <= 4'd0;
      wishbone_stb_o  <= 1'b0;
      wishbone_cyc_o  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cpu_ce_i && !flush_i) begin
            wishbone_addr_o <= cpu_addr_i;
            wishbone_data_o <= cpu_data_i;
            wishbone_we_o   <= cpu_we_i;
            wishbone_sel_o  <= cpu_sel_i;
            wishbone_stb_o  <= 1'b1;
            wishbone_cyc_o  <= 1'b1;
            state_r         <= BUSY;
          end
        end
        BUSY: begin
          // ack wins over flush/timeout: the slave has already completed the access
          if (wishbone_ack_i) begin
            if (!wishbone_we_o) begin
              rd_buf_r <= wishbone_data_i;
            end
            wishbone_addr_o <= 32'd0;
            wishbone_data_o <= 32'd0;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= 4'd0;
            wishbone_stb_o  <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
            state_r         <= (stall_i != 6'd0) ? WAIT_FOR_STALL : IDLE;
          end else if (flush_i || timeout_s) begin
            rd_buf_r        <= 32'd0;
            wishbone_addr_o <= 32'd0;
            wishbone_data_o <= 32'd0;
            wishbone_we_o   <= 1'b0;
            wishbone_sel_o  <= 4'd0;
            wishbone_stb_o  <= 1'b0;
            wishbone_cyc_o  <= 1'b0;
            state_r         <= IDLE;
          end
        end
        WAIT_FOR_STALL: begin
          if (stall_i == 6'd0) begin
            state_r <= IDLE;
          end
        end
        default: begin
          state_r        <= IDLE;
          wishbone_stb_o <= 1'b0;
          wishbone_cyc_o <= 1'b0;
        end
      endcase
    end
  end

  // CPU-facing handshake decoded from state and live bus inputs
  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = 32'd0;
    if (rst) begin
      stallreq_o = 1'b0;
      cpu_data_o = 32'd0;
    end else begin
      case (state_r)
        IDLE: begin
          stallreq_o = cpu_ce_i & ~flush_i;
        end
        BUSY: begin
          if (wishbone_ack_i) begin
            stallreq_o = 1'b0;
            cpu_data_o = wishbone_we_o ? 32'd0 : wishbone_data_i;
          end else begin
            stallreq_o = 1'b1;
            cpu_data_o = 32'd0;
          end
        end
        WAIT_FOR_STALL: begin
          cpu_data_o = rd_buf_r;
        end
        default: begin
          stallreq_o = 1'b0;
          cpu_data_o = 32'd0;
        end
      endcase
    end
  end

endmodule

// File: doc/wishbone_bus_if.md
WISHBONE_BUS_IF -- requirements
Module: wishbone_bus_if

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, giving the number of BUSY cycles without ack before abort; legal range 1..65535; used only when WB_BUS_TIMEOUT_EN is defined.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port stall_i, input, 6 bits: pipeline stall vector from ctrl.
REQ-005 SHALL have port flush_i, input, 1 bit: pipeline flush from ctrl (exception).
REQ-006 SHALL have port cpu_ce_i, input, 1 bit: CPU access request.
REQ-007 SHALL have the following CPU-side ports: cpu_addr_i (input, 32 bits, access address), cpu_data_i (input, 32 bits, write data), cpu_we_i (input, 1 bit, 1 = write), cpu_sel_i (input, 4 bits, byte select).
REQ-008 SHALL have port cpu_data_o, output, 32 bits: read data returned to the CPU.
REQ-009 SHALL have port stallreq_o, output, 1 bit: stall request to ctrl while an access is outstanding.
REQ-010 SHALL have the following Wishbone-side inputs: wishbone_data_i (32 bits, read data) and wishbone_ack_i (1 bit, slave acknowledge).
REQ-011 SHALL have the following Wishbone-side outputs: wishbone_addr_o (32 bits), wishbone_data_o (32 bits), wishbone_we_o (1 bit), wishbone_sel_o (4 bits), wishbone_stb_o (1 bit), wishbone_cyc_o (1 bit).
REQ-012 SHALL have port bus_err_o, output, 1 bit: one-cycle pulse when an access is aborted on timeout.

Function
REQ-013 SHALL implement three states: IDLE, BUSY and WAIT_FOR_STALL.
REQ-014 In IDLE, when cpu_ce_i=1 and flush_i=0, SHALL register cyc=stb=1 together with cpu_addr_i, cpu_data_i, cpu_we_i and cpu_sel_i onto the Wishbone outputs, and go to BUSY.
REQ-015 In IDLE, when cpu_ce_i=1 and flush_i=1, SHALL issue no cycle and remain in IDLE.
REQ-016 In BUSY with wishbone_ack_i=1, the following edge SHALL clear cyc, stb, we, addr, data and sel to 0.
REQ-017 On that BUSY ack edge, if we=0 SHALL capture wishbone_data_i into a 32-bit read buffer.
REQ-018 On that BUSY ack edge, SHALL go to WAIT_FOR_STALL if stall_i≠0, else to IDLE.
REQ-019 In BUSY with ack=0 and flush_i=1, SHALL abort: clear cyc, stb and all Wishbone outputs, clear the read buffer, and go to IDLE.
REQ-020 In BUSY, ack=1 SHALL take priority over a simultaneous flush_i=1.
REQ-021 In WAIT_FOR_STALL, SHALL go to IDLE when stall_i=0, and otherwise hold.
REQ-022 stallreq_o and cpu_data_o SHALL be combinational from state and inputs, as follows:
- IDLE: stallreq_o = cpu_ce_i & ~flush_i; cpu_data_o = 0.
- BUSY with ack: stallreq_o = 0; cpu_data_o = wishbone_data_i if we=0, else 0.
- BUSY without ack: stallreq_o = 1; cpu_data_o = 0.
- WAIT_FOR_STALL: stallreq_o = 0; cpu_data_o = read buffer.
REQ-023 SHALL keep exactly one Wishbone cycle outstanding and SHALL not assert stb unless cyc is asserted.
REQ-024 Read latency SHALL be: request seen in IDLE, stb on the next cycle, data to the CPU in the same cycle ack is seen.

Reset
REQ-025 While rst=1, SHALL asynchronously force state to IDLE and clear all Wishbone outputs, the read buffer, the timeout counter and bus_err_o.
REQ-026 While rst=1, combinational outputs SHALL be stallreq_o=0 and cpu_data_o=0.
REQ-027 A reset asserted during BUSY SHALL drop cyc and stb immediately, without waiting for a clock edge.

Configuration
REQ-028 With WB_BUS_TIMEOUT_EN defined, SHALL count consecutive BUSY cycles without ack, clearing the count on entry to BUSY.
REQ-029 With WB_BUS_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYCLES, SHALL abort as in REQ-019, pulse bus_err_o for one cycle and return to IDLE, with cpu_data_o=0.
REQ-030 With WB_BUS_TIMEOUT_EN undefined, SHALL omit the counter, hold bus_err_o at 0, and wait in BUSY indefinitely.

Verification
REQ-031 SHALL cover single read: cpu_ce=1, we=0, addr=0x100 -> stb/cyc=1 next cycle with addr=0x100; ack after 3 cycles with data=0xDEADBEEF -> cpu_data_o=0xDEADBEEF and stallreq_o=0 in the ack cycle; state returns to IDLE.
REQ-032 SHALL cover write: addr=0x200, data=0x12345678, sel=4'b0011, we=1 -> Wishbone outputs match; stallreq_o=1 until ack; cpu_data_o=0.
REQ-033 SHALL cover read ack while stall_i=6'b001111 held for 2 cycles -> WAIT_FOR_STALL; cpu_data_o holds the buffered 0xCAFEF00D until stall_i=0, then IDLE.
REQ-034 SHALL cover flush_i=1 in BUSY without ack -> cyc/stb=0 next cycle, IDLE, no data returned; flush_i and ack together -> ack honoured.
REQ-035 SHALL cover rst pulse mid-BUSY -> cyc/stb drop asynchronously; after release, a new read completes normally.
REQ-036 SHALL cover, with WB_BUS_TIMEOUT_EN defined and TIMEOUT_CYCLES=4, no ack -> abort after 4 BUSY cycles with a 1-cycle bus_err_o pulse; without the macro, stallreq_o stays 1.
